adder_char_engine: RTL and testbench

Synthesizable exhaustive characterization engine for approximate adders. On `start`, it sweeps every operand pair (a outer, b inner) into an external approximate adder and samples that adder's sum. It compares each sample against a pipelined exact sum and accumulates raw error statistics: error count, signed sum, absolute sum, squared sum and max absolute error. It sits on the operand side of any approximate-adder DUT, and software derives ER/AE/MAE/MSE/RMSE/MEP from its counters.

---
 rtl/adder_char_pkg.sv | 10 +
 rtl/adder_char_engine_accum.sv | 46 ++++
 rtl/adder_char_engine.sv | 91 +++++++++
 tb/tb_adder_char_engine.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/adder_char_pkg.sv
// adder_char_pkg: FSM state type and width helpers shared by the characterization engine
package adder_char_pkg;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} char_state_t;
   function automatic int sum_w(input int w);   return w + 1;     endfunction
   function automatic int err_w(input int w);   return w + 2;     endfunction
   function automatic int count_w(input int w); return 2*w + 1;   endfunction
   function automatic int esum_w(input int w);  return 3*w + 2;   endfunction
   function automatic int asum_w(input int w);  return 3*w + 1;   endfunction
   function automatic int sq_w(input int w);    return 4*w + 2;   endfunction
endpackage

// File: rtl/adder_char_engine_accum.sv
// adder_err_accum: accumulates error statistics of approx vs exact sums
module adder_err_accum import adder_char_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic valid,
   input  logic [sum_w(WIDTH)-1:0] exact,
   input  logic [sum_w(WIDTH)-1:0] approx,
   output logic [count_w(WIDTH)-1:0] case_count,
   output logic [count_w(WIDTH)-1:0] err_count,
   output logic signed [esum_w(WIDTH)-1:0] err_sum,
   output logic [asum_w(WIDTH)-1:0] abs_err_sum,
   output logic [sq_w(WIDTH)-1:0] sq_err_sum,
   output logic [sum_w(WIDTH)-1:0] max_abs_err
);
   localparam int SW = sum_w(WIDTH);
   localparam int EW = err_w(WIDTH);
   localparam int PW = 2*WIDTH + 2;
   logic signed [EW-1:0] err;
   logic [SW-1:0] mag;
   logic [PW-1:0] sq;
   always_comb begin
      err = $signed({1'b0, approx}) - $signed({1'b0, exact});
      mag = err[EW-1] ? SW'(-err) : SW'(err);
      sq  = PW'(mag) * PW'(mag);
   end
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         case_count  <= '0;
         err_count   <= '0;
         err_sum     <= '0;
         abs_err_sum <= '0;
         sq_err_sum  <= '0;
         max_abs_err <= '0;
      end else if (valid) begin
         case_count  <= case_count + 1'b1;
         err_count   <= err_count + count_w(WIDTH)'(err != '0);
         err_sum     <= err_sum + esum_w(WIDTH)'(err);
         abs_err_sum <= abs_err_sum + asum_w(WIDTH)'(mag);
         sq_err_sum  <= sq_err_sum + sq_w(WIDTH)'(sq);
         max_abs_err <= mag > max_abs_err ? mag : max_abs_err;
      end
   end
endmodule

// File: rtl/adder_char_engine.sv
// adder_char_engine: exhaustive operand sweep driving an approximate adder and
// accumulating its error statistics against a latency-aligned exact sum.
module adder_char_engine import adder_char_pkg::*; #(
   parameter int WIDTH       = 8,
   parameter int DUT_LATENCY = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic op_valid,
   input  logic [sum_w(WIDTH)-1:0] approx_sum,
   output logic busy,
   output logic done,
   output logic [count_w(WIDTH)-1:0] case_count,
   output logic [count_w(WIDTH)-1:0] err_count,
   output logic signed [esum_w(WIDTH)-1:0] err_sum,
   output logic [asum_w(WIDTH)-1:0] abs_err_sum,
   output logic [sq_w(WIDTH)-1:0] sq_err_sum,
   output logic [sum_w(WIDTH)-1:0] max_abs_err
);
   localparam int SW = sum_w(WIDTH);
   localparam int DW = $clog2(DUT_LATENCY + 1) + 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DUT_LATENCY == 0 ? 0 : DUT_LATENCY - 1);
   char_state_t state, nxt;
   logic go, last, drain_end;
   logic [DW-1:0] drain_cnt;
   logic [SW-1:0] exact, al_exact;
   logic al_valid;
   always_comb begin
      go        = start && (state == IDLE || state == DONE);
      last      = state == SWEEP && (&op_a) && (&op_b);
      drain_end = state == DRAIN && drain_cnt == DRAIN_LAST;
      nxt       = go ? SWEEP : last ? (DUT_LATENCY == 0 ? DONE : DRAIN) : drain_end ? DONE : state;
      exact     = SW'(op_a) + SW'(op_b);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         op_valid  <= 1'b0;
         drain_cnt <= '0;
      end else begin
         state     <= nxt;
         drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
         if (go) begin
            {op_a, op_b} <= '0;
            op_valid     <= 1'b1;
         end else if (state == SWEEP) begin
            op_valid <= !last;
            // b is the low half, so a single increment carries into a on b wrap
            if (!last) {op_a, op_b} <= {op_a, op_b} + 1'b1;
         end
      end
   end
   assign busy = state == SWEEP || state == DRAIN;
   assign done = state == DONE;
   generate
      if (DUT_LATENCY == 0) begin : g_comb
         assign al_valid = op_valid;
         assign al_exact = exact;
      end else begin : g_dly
         logic [SW:0] dly [DUT_LATENCY];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DUT_LATENCY; i++) dly[i] <= '0;
            end else begin
               dly[0] <= {op_valid, exact};
               for (int i = 1; i < DUT_LATENCY; i++) dly[i] <= dly[i-1];
            end
         end
         assign {al_valid, al_exact} = dly[DUT_LATENCY-1];
      end
   endgenerate
   adder_err_accum #(.WIDTH(WIDTH)) u_accum (
      .clk(clk),
      .rst(rst),
      .clear(go),
      .valid(al_valid),
      .exact(al_exact),
      .approx(approx_sum),
      .case_count(case_count),
      .err_count(err_count),
      .err_sum(err_sum),
      .abs_err_sum(abs_err_sum),
      .sq_err_sum(sq_err_sum),
      .max_abs_err(max_abs_err)
   );
endmodule

// File: tb/tb_adder_char_engine.sv
// tb_adder_char_engine: WIDTH=2 engines at latency 0 and 2 driving modelled adders
module tb_adder_char_engine;
   logic clk = 0, rst = 1, start0 = 0, start2 = 0;
   int mode = 0, sel_lat = 0;
   always #5 clk = ~clk;
   logic [1:0] a0, b0, a2, b2;
   logic ov0, ov2, busy0, busy2, done0, done2;
   logic [2:0] approx0, approx2, p1, p2;
   logic [4:0] cc0, cc2, ec0, ec2;
   logic signed [7:0] es0, es2;
   logic [6:0] as0, as2;
   logic [9:0] sq0, sq2;
   logic [2:0] mx0, mx2;
   logic s_ov, s_busy, s_done;
   logic [1:0] s_a, s_b;
   logic [4:0] s_cc, s_ec;
   logic signed [7:0] s_es;
   logic [6:0] s_as;
   logic [9:0] s_sq;
   logic [2:0] s_mx;
   typedef struct {int mode; int lat; int cycles; int cc; int ec; int es; int as; int sq; int mx;} vec_t;
   vec_t vecs[6];
   vec_t sb[$];
   int tests = 0, fails = 0;
   function automatic logic [2:0] model(input int m, input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return m == 1 ? (s & 3'b110) : m == 2 ? 3'd0 : m == 3 ? {1'b0, a | b} : s;
   endfunction
   assign approx0 = model(mode, a0, b0);
   always_ff @(posedge clk) begin
      p1 <= model(mode, a2, b2);
      p2 <= p1;
   end
   assign approx2 = p2;
   adder_char_engine #(.WIDTH(2), .DUT_LATENCY(0)) u0 (
      .clk(clk), .rst(rst), .start(start0), .op_a(a0), .op_b(b0), .op_valid(ov0),
      .approx_sum(approx0), .busy(busy0), .done(done0), .case_count(cc0), .err_count(ec0),
      .err_sum(es0), .abs_err_sum(as0), .sq_err_sum(sq0), .max_abs_err(mx0));
   adder_char_engine #(.WIDTH(2), .DUT_LATENCY(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .op_a(a2), .op_b(b2), .op_valid(ov2),
      .approx_sum(approx2), .busy(busy2), .done(done2), .case_count(cc2), .err_count(ec2),
      .err_sum(es2), .abs_err_sum(as2), .sq_err_sum(sq2), .max_abs_err(mx2));
   always_comb begin
      s_ov   = sel_lat == 0 ? ov0 : ov2;
      s_busy = sel_lat == 0 ? busy0 : busy2;
      s_done = sel_lat == 0 ? done0 : done2;
      s_a    = sel_lat == 0 ? a0 : a2;
      s_b    = sel_lat == 0 ? b0 : b2;
      s_cc   = sel_lat == 0 ? cc0 : cc2;
      s_ec   = sel_lat == 0 ? ec0 : ec2;
      s_es   = sel_lat == 0 ? es0 : es2;
      s_as   = sel_lat == 0 ? as0 : as2;
      s_sq   = sel_lat == 0 ? sq0 : sq2;
      s_mx   = sel_lat == 0 ? mx0 : mx2;
   end
   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic set_start(input int lat, input logic v);
      if (lat == 0) start0 = v;
      else start2 = v;
   endtask
   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {s_ov, s_busy, s_done, s_a, s_b}, 0);
      check({tag, "_cc"}, s_cc, 0);
      check({tag, "_ec"}, s_ec, 0);
      check({tag, "_es"}, s_es, 0);
      check({tag, "_as"}, s_as, 0);
      check({tag, "_sq"}, s_sq, 0);
      check({tag, "_mx"}, s_mx, 0);
   endtask
   task automatic run(input vec_t v, input int mid);
      int n;
      vec_t e;
      sb.push_back(v);
      sel_lat = v.lat;
      @(negedge clk);
      mode = v.mode;
      set_start(v.lat, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_start(v.lat, 1'b0);
      n = 0;
      check("start_busy_done", {s_busy, s_done}, 2'b10);
      check("start_clear", s_cc, 0);
      check("start_pair", {s_ov, s_a, s_b}, 5'b10000);
      while (!s_done && n < 200) begin
         @(negedge clk);
         n++;
         set_start(v.lat, mid != 0 && n == mid);
         if (v.lat == 2 && (n == 16 || n == 17)) check("drain_ov_busy", {s_ov, s_busy}, 2'b01);
      end
      set_start(v.lat, 1'b0);
      e = sb.pop_front();
      check("done_cycle", n, e.cycles);
      check("done_busy", s_busy, 0);
      check("case_count", s_cc, e.cc);
      check("err_count", s_ec, e.ec);
      check("err_sum", s_es, e.es);
      check("abs_err_sum", s_as, e.as);
      check("sq_err_sum", s_sq, e.sq);
      check("max_abs_err", s_mx, e.mx);
   endtask
   initial begin
      vecs[0] = '{0, 0, 16, 16, 0, 0, 0, 0, 0};
      vecs[1] = '{1, 0, 16, 16, 8, -8, 8, 8, 1};
      vecs[2] = '{2, 0, 16, 16, 15, -48, 48, 184, 6};
      vecs[3] = '{3, 0, 16, 16, 7, -12, 12, 24, 3};
      vecs[4] = '{0, 2, 18, 16, 0, 0, 0, 0, 0};
      vecs[5] = '{2, 2, 18, 16, 15, -48, 48, 184, 6};
      repeat (3) @(negedge clk);
      check_zero("reset0");
      sel_lat = 2;
      check_zero("reset2");
      rst = 0;
      for (int i = 0; i < 6; i++) run(vecs[i], 0);
      run(vecs[2], 7);
      run(vecs[3], 3);
      sel_lat = 0;
      @(negedge clk);
      mode = 2;
      start0 = 1;
      @(posedge clk);
      @(negedge clk);
      start0 = 0;
      repeat (4) @(negedge clk);
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      check_zero("midreset");
      rst = 0;
      run(vecs[1], 0);
      run(vecs[1], 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
